// File: rtl/fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_if
//
// Groups the producer handshake, the FIFO write port and the arbiter status
// signals of fifo_write_arbiter into one bundle.
//
// Parameters:
//   NREQ  - number of producer streams
//   WIDTH - data word width (FIFO word)
//   IDW   - width of grant_id, clog2(NREQ)
//
// Signals:
//   req_valid     [NREQ]        producer i presents a word
//   req_data      [NREQ*WIDTH]  word of producer i in [i*WIDTH +: WIDTH]
//   req_last      [NREQ]        presented word ends producer i's packet
//   req_ready     [NREQ]        word of producer i accepted this cycle
//   fifo_full                   FIFO full flag
//   fifo_write_en               write strobe to the FIFO
//   fifo_data_in  [WIDTH]       write data to the FIFO
//   grant_valid                 a producer currently owns the write port
//   grant_id      [IDW]         current owner (0 when no owner)
//   words_written [16]          running count of accepted words (wraps)
//
// Modports:
//   master - producer/FIFO side (drives requests and the full flag)
//   slave  - arbiter side
// ---------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_write_en;
  logic [WIDTH-1:0]      fifo_data_in;
  logic                  grant_valid;
  logic [IDW-1:0]        grant_id;
  logic [15:0]           words_written;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output fifo_full,
    input  req_ready,
    input  fifo_write_en,
    input  fifo_data_in,
    input  grant_valid,
    input  grant_id,
    input  words_written
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifo_full,
    output req_ready,
    output fifo_write_en,
    output fifo_data_in,
    output grant_valid,
    output grant_id,
    output words_written
  );

endinterface

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing one FIFO write port between NREQ producer
// streams. One producer owns the port at a time for at most BURST words;
// ownership ends early on a packet's last word or when the owner stops
// presenting data. Writes are gated by the FIFO full flag and every accepted
// word is counted in a wrapping 16-bit counter.
//
// Parameters:
//   NREQ  - number of producers (2..8)
//   WIDTH - data word width
//   BURST - maximum words per grant (1..15)
//   IDW   - width of grant_id, clog2(NREQ)
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - fifo_write_arbiter_if.slave (handshake, FIFO port, status)
//
// req_ready, fifo_write_en and fifo_data_in are combinational from the
// registered state and the current inputs; grant_valid, grant_id and
// words_written come from registers only.
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_write_arbiter_if.slave  bus
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Beat count value of the final word a grant may carry.
  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [0:0]     r_state;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_rr_ptr;
  logic [3:0]     r_beat_cnt;
  logic [15:0]    r_words_written;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [0:0]     w_state_next;
  logic [IDW-1:0] w_owner_next;
  logic [IDW-1:0] w_rr_ptr_next;
  logic [3:0]     w_beat_cnt_next;
  logic [15:0]    w_words_written_next;

  logic [WIDTH-1:0] w_word [NREQ];     // per-producer data slices
  logic [IDW-1:0]   w_cand_idx [NREQ]; // producer examined at search offset gi
  logic [NREQ-1:0]  w_rot_valid;       // req_valid rotated to start at rr_ptr
  logic [NREQ-1:0]  w_req_ready;

  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic           w_lock;
  logic           w_owner_valid;
  logic           w_owner_last;
  logic           w_owner_ready;
  logic           w_transfer;
  logic           w_release;
  logic [IDW-1:0] w_owner_inc;

  // -------------------------------------------------------------------------
  // Per-producer slices, rotated request view and ready decode
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IDW:0] w_sum;

      assign w_word[gi] = bus.req_data[gi*WIDTH +: WIDTH];

      // rr_ptr + gi folded back into 0..NREQ-1; one extra bit keeps the sum
      // from overflowing before the fold, and NREQ need not be a power of 2.
      assign w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(gi);
      assign w_cand_idx[gi] = (w_sum >= (IDW+1)'(NREQ))
                              ? IDW'(w_sum - (IDW+1)'(NREQ))
                              : w_sum[IDW-1:0];
      assign w_rot_valid[gi] = bus.req_valid[w_cand_idx[gi]];

      // Only the owner's bit can ever be set.
      assign w_req_ready[gi] = w_owner_ready & (r_owner == IDW'(gi));
    end
  endgenerate

  // First valid producer at or after rr_ptr. Scanning from the far end
  // downwards lets the smallest offset overwrite any later candidate.
  always_comb begin
    w_found  = |w_rot_valid;
    w_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot_valid[k]) begin
        w_winner = w_cand_idx[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Owner handshake
  // -------------------------------------------------------------------------
  assign w_lock        = (r_state == ST_LOCK);
  assign w_owner_valid = bus.req_valid[r_owner];
  assign w_owner_last  = bus.req_last[r_owner];
  assign w_owner_ready = w_lock & w_owner_valid & ~bus.fifo_full;
  assign w_transfer    = w_owner_valid & w_owner_ready;

  // Ownership ends on the last beat of a burst, on the packet's last word,
  // or as soon as the owner withdraws its request. A full stall alone never
  // releases.
  assign w_release = w_lock &
                     (~w_owner_valid |
                      (w_transfer & (w_owner_last | (r_beat_cnt == LAST_BEAT))));

  assign w_owner_inc = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + IDW'(1);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next         = r_state;
    w_owner_next         = r_owner;
    w_rr_ptr_next        = r_rr_ptr;
    w_beat_cnt_next      = r_beat_cnt;
    w_words_written_next = r_words_written;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_next    = ST_LOCK;
          w_owner_next    = w_winner;
          w_beat_cnt_next = '0;
        end
      end

      ST_LOCK: begin
        if (w_transfer) begin
          w_beat_cnt_next      = r_beat_cnt + 4'd1;
          w_words_written_next = r_words_written + 16'd1;
        end
        if (w_release) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = w_owner_inc;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_owner         <= '0;
      r_rr_ptr        <= '0;
      r_beat_cnt      <= '0;
      r_words_written <= '0;
    end else begin
      r_state         <= w_state_next;
      r_owner         <= w_owner_next;
      r_rr_ptr        <= w_rr_ptr_next;
      r_beat_cnt      <= w_beat_cnt_next;
      r_words_written <= w_words_written_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.req_ready     = w_req_ready;
  assign bus.fifo_write_en = w_transfer;
  // Plain mux; the value only matters while fifo_write_en is high.
  assign bus.fifo_data_in  = w_word[r_owner];
  assign bus.grant_valid   = w_lock;
  assign bus.grant_id      = w_lock ? r_owner : '0;
  assign bus.words_written = r_words_written;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Directed scenarios for fifo_write_arbiter. Producers are queues of words
// that present their head word and pop it when it is accepted. A reference
// model of the arbitration rules predicts every output on every cycle; each
// scenario also checks hand-computed grant order, write cycles and counts.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int BURST = 4;
  localparam int IDW   = 2;
  localparam int QD    = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) arb_if ();

  fifo_write_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .BURST(BURST),
    .IDW  (IDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(arb_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Producer word queues
  logic [31:0] pdata [NREQ][QD];
  logic        plast [NREQ][QD];
  int          phead [NREQ];
  int          ptail [NREQ];
  logic [NREQ-1:0] acc;

  // Scenario cycle and schedules (inclusive ranges, empty when from > to)
  int sc_cyc;
  int rst_from, rst_to, full_from, full_to, drop_id, drop_from, drop_to;

  // Logs filled by the compare process
  int          glog [$];
  int          wcyc [$];
  logic [31:0] wdata [$];

  // Reference model state
  int  m_owner = -1;
  int  m_rr    = 0;
  int  m_beats = 0;
  int  m_words = 0;
  bit  prev_gv = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, sc_cyc);
    end
  endtask

  task automatic chk_list(string name, int got[$], int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      chk(name, got[k], exp[k]);
  endtask

  // ---------------------------------------------------------------------
  // Compare process: model prediction vs DUT, every falling edge
  // ---------------------------------------------------------------------
  initial begin
    logic [NREQ-1:0]  e_ready;
    logic             e_we;
    logic             e_gv;
    logic [IDW-1:0]   e_gid;
    logic [WIDTH-1:0] e_data;
    bit               xfer;
    bit               rel;
    forever begin
      @(negedge clk);
      e_ready = '0; e_we = 1'b0; e_gv = 1'b0; e_gid = '0; e_data = '0;
      xfer = 1'b0; rel = 1'b0;
      if (!rst) begin
        m_owner = -1; m_rr = 0; m_beats = 0; m_words = 0;
      end else if (m_owner >= 0) begin
        e_gv  = 1'b1;
        e_gid = IDW'(m_owner);
        if (arb_if.req_valid[m_owner] && !arb_if.fifo_full) begin
          xfer = 1'b1;
          e_ready[m_owner] = 1'b1;
          e_we = 1'b1;
          e_data = arb_if.req_data[m_owner*WIDTH +: WIDTH];
        end
      end
      chk("req_ready",     32'(arb_if.req_ready),     32'(e_ready));
      chk("fifo_write_en", 32'(arb_if.fifo_write_en), 32'(e_we));
      chk("grant_valid",   32'(arb_if.grant_valid),   32'(e_gv));
      chk("grant_id",      32'(arb_if.grant_id),      32'(e_gid));
      chk("words_written", 32'(arb_if.words_written), 32'(m_words));
      if (e_we) chk("fifo_data_in", arb_if.fifo_data_in, e_data);

      if (arb_if.fifo_write_en) begin
        wcyc.push_back(sc_cyc);
        wdata.push_back(arb_if.fifo_data_in);
      end
      if (arb_if.grant_valid && !prev_gv) glog.push_back(int'(arb_if.grant_id));
      prev_gv = arb_if.grant_valid;
      acc = arb_if.req_ready & arb_if.req_valid;

      // Advance the model across the coming rising edge
      if (rst) begin
        if (m_owner < 0) begin
          for (int k = 0; k < NREQ; k++) begin
            if (m_owner < 0 && arb_if.req_valid[(m_rr + k) % NREQ]) begin
              m_owner = (m_rr + k) % NREQ;
              m_beats = 0;
            end
          end
        end else begin
          rel = !arb_if.req_valid[m_owner] ||
                (xfer && (arb_if.req_last[m_owner] || m_beats == BURST - 1));
          if (xfer) begin
            m_beats++;
            m_words = (m_words + 1) % 65536;
          end
          if (rel) begin
            m_rr    = (m_owner + 1) % NREQ;
            m_owner = -1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic drive();
    rst = !(sc_cyc >= rst_from && sc_cyc <= rst_to);
    arb_if.fifo_full = (sc_cyc >= full_from && sc_cyc <= full_to);
    for (int i = 0; i < NREQ; i++) begin
      bit en;
      en = !(i == drop_id && sc_cyc >= drop_from && sc_cyc <= drop_to);
      if (en && phead[i] < ptail[i]) begin
        arb_if.req_valid[i] = 1'b1;
        arb_if.req_data[i*WIDTH +: WIDTH] = pdata[i][phead[i]];
        arb_if.req_last[i] = plast[i][phead[i]];
      end else begin
        arb_if.req_valid[i] = 1'b0;
        arb_if.req_data[i*WIDTH +: WIDTH] = '0;
        arb_if.req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) phead[i]++;
    sc_cyc++;
    drive();
  endtask

  task automatic run_to(int n);
    while (sc_cyc < n) step();
  endtask

  task automatic load(int r, logic [31:0] d, logic l);
    pdata[r][ptail[r]] = d;
    plast[r][ptail[r]] = l;
    ptail[r]++;
  endtask

  task automatic start_scn();
    sc_cyc = 0;
    rst_from = -1; rst_to = -2;
    full_from = -1; full_to = -2;
    drop_id = -1; drop_from = -1; drop_to = -2;
    glog.delete(); wcyc.delete(); wdata.delete();
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  initial begin
    int e[$];
    for (int i = 0; i < NREQ; i++) begin
      phead[i] = 0; ptail[i] = 0;
    end
    acc = '0;
    arb_if.req_valid = '0;
    arb_if.req_data  = '0;
    arb_if.req_last  = '0;
    arb_if.fifo_full = 1'b0;
    start_scn();
    rst = 1'b1;
    #2 rst = 1'b0;
    rst_from = 0; rst_to = 2;

    // Reset state, with every producer presenting a word
    step();
    arb_if.req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(arb_if.req_ready), 0);
    chk("rst_write_en",  32'(arb_if.fifo_write_en), 0);
    chk("rst_grant_valid", 32'(arb_if.grant_valid), 0);
    chk("rst_grant_id", 32'(arb_if.grant_id), 0);
    chk("rst_words", 32'(arb_if.words_written), 0);
    drive();
    run_to(5);

    // Single requester, 6 words
    start_scn();
    for (int k = 0; k < 6; k++) load(0, 32'hA000_0000 + 32'(k), 1'b0);
    drive();
    run_to(10);
    e = '{1, 2, 3, 4, 6, 7}; chk_list("s1_write_cycles", wcyc, e);
    e = '{0, 0};             chk_list("s1_grants", glog, e);
    chk("s1_fifo_len", wdata.size(), 6);
    for (int k = 0; k < 6 && k < wdata.size(); k++)
      chk("s1_fifo_word", wdata[k], 32'hA000_0000 + 32'(k));
    chk("s1_words", 32'(arb_if.words_written), 6);

    // Contention between requesters 1 and 2
    start_scn();
    for (int k = 0; k < 8; k++) begin
      load(1, 32'hB100_0000 + 32'(k), 1'b0);
      load(2, 32'hB200_0000 + 32'(k), 1'b0);
    end
    drive();
    run_to(22);
    e = '{1, 2, 1, 2}; chk_list("s2_grants", glog, e);
    chk("s2_writes", wcyc.size(), 16);
    chk("s2_words", 32'(arb_if.words_written), 22);

    // Round-robin wrap: pointer at 3, requesters 0 and 3 both valid
    start_scn();
    load(0, 32'hC000_0000, 1'b0); load(0, 32'hC000_0001, 1'b1);
    load(3, 32'hC300_0000, 1'b0); load(3, 32'hC300_0001, 1'b1);
    drive();
    run_to(8);
    e = '{3, 0};       chk_list("s3_grants", glog, e);
    e = '{1, 2, 4, 5}; chk_list("s3_write_cycles", wcyc, e);
    chk("s3_words", 32'(arb_if.words_written), 26);

    // Full stall for 3 cycles after 2 beats
    start_scn();
    for (int k = 0; k < 4; k++) load(1, 32'hD100_0000 + 32'(k), 1'b0);
    full_from = 3; full_to = 5;
    drive();
    run_to(10);
    e = '{1};          chk_list("s4_grants", glog, e);
    e = '{1, 2, 6, 7}; chk_list("s4_write_cycles", wcyc, e);
    chk("s4_words", 32'(arb_if.words_written), 30);

    // Move the pointer to 3 with a single word from requester 2
    start_scn();
    load(2, 32'hE200_0000, 1'b1);
    drive();
    run_to(4);
    chk("p1_words", 32'(arb_if.words_written), 31);

    // Early release on req_last at beat 2
    start_scn();
    load(1, 32'hE100_0000, 1'b0);
    load(1, 32'hE100_0001, 1'b1);
    load(1, 32'hE100_0002, 1'b0);
    load(2, 32'hE200_0001, 1'b1);
    drive();
    run_to(9);
    e = '{1, 2, 1};    chk_list("s5_grants", glog, e);
    e = '{1, 2, 4, 6}; chk_list("s5_write_cycles", wcyc, e);
    chk("s5_words", 32'(arb_if.words_written), 35);

    // Requester 1 withdraws after beat 1
    start_scn();
    for (int k = 0; k < 3; k++) load(1, 32'hF100_0000 + 32'(k), 1'b0);
    drop_id = 1; drop_from = 2; drop_to = 3;
    drive();
    run_to(9);
    e = '{1, 1};    chk_list("s6_grants", glog, e);
    e = '{1, 5, 6}; chk_list("s6_write_cycles", wcyc, e);
    chk("s6_words", 32'(arb_if.words_written), 38);

    // Pointer to 3 again
    start_scn();
    load(2, 32'h9200_0000, 1'b1);
    drive();
    run_to(4);
    chk("p2_words", 32'(arb_if.words_written), 39);

    // Reset during beat 3 of requester 2's burst
    start_scn();
    for (int k = 0; k < 6; k++) load(2, 32'h8200_0000 + 32'(k), 1'b0);
    rst_from = 3; rst_to = 4;
    drop_id = 2; drop_from = 5; drop_to = 1000;
    drive();
    run_to(3);
    #1;
    chk("s7_rst_req_ready", 32'(arb_if.req_ready), 0);
    chk("s7_rst_write_en", 32'(arb_if.fifo_write_en), 0);
    chk("s7_rst_grant_valid", 32'(arb_if.grant_valid), 0);
    chk("s7_rst_words", 32'(arb_if.words_written), 0);
    run_to(5);
    load(1, 32'h8100_0000, 1'b1);
    load(3, 32'h8300_0000, 1'b1);
    drive();
    run_to(10);
    e = '{2, 1, 3};    chk_list("s7_grants", glog, e);
    e = '{1, 2, 6, 8}; chk_list("s7_write_cycles", wcyc, e);
    chk("s7_words", 32'(arb_if.words_written), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
